mem_block_mover: RTL and testbench
==================================

Name: mem_block_mover

Overview:
- Bus initiator for the single-port, word-indexed data memory: drives mem_r_en / mem_w_en / address / write data.
- Copies a block of words from source to destination, or fills a block with a constant (memset).
- Sits beside the pipeline MEM stage as a second master. An external mux grants it the memory while busy=1.
- The memory read path is combinational: data is valid in the same cycle that r_en and address are asserted. Writes commit at the clk edge.

Parameters:
ADDR_W, 32, width of memory address / pointer registers
DATA_W, 32, memory word width
CNT_W, 7, width of word_count (max 64 words plus the zero case)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  one-cycle request; sampled only in IDLE
mode  input  1  0 = copy, 1 = fill; latched at start
src_addr  input  ADDR_W  first source word index (copy mode only)
dst_addr  input  ADDR_W  first destination word index
word_count  input  CNT_W  number of words to move
fill_value  input  DATA_W  word written in fill mode; latched at start
busy  output  1  high from the cycle after an accepted start through the DONE cycle
done  output  1  one-cycle pulse on completion
words_done  output  CNT_W  words written so far in the current or last operation
mem_r_en  output  1  memory read enable
mem_w_en  output  1  memory write enable
mem_address  output  ADDR_W  memory word index
mem_wdata  output  DATA_W  data to memory
mem_rdata  input  DATA_W  data from memory (combinational)

Behaviour:
- Reset (synchronous, takes priority over everything):
  - state = IDLE.
  - busy, done, mem_r_en, mem_w_en = 0; mem_address, mem_wdata = 0.
  - words_done = 0; internal pointers, remaining count and data buffer = 0.
- States: IDLE, READ, WRITE, DONE.
- Memory outputs are decoded from state and registers. Any output not listed for a state is 0.
- IDLE:
  - On start=1, latch src_ptr, dst_ptr, remaining=word_count, mode and fill_value; clear words_done.
  - Next state:
    - word_count = 0 → DONE.
    - mode = 1 → WRITE.
    - otherwise → READ.
  - start=0 → stay in IDLE.
- READ (copy only):
  - mem_r_en=1, mem_address=src_ptr.
  - At the edge: buffer ← mem_rdata; src_ptr += 1; next state WRITE.
- WRITE:
  - mem_w_en=1, mem_address=dst_ptr.
  - mem_wdata = buffer in copy mode, fill_value in fill mode.
  - At the edge: dst_ptr += 1; remaining −= 1; words_done += 1.
  - Next state:
    - remaining was 1 → DONE.
    - else copy → READ, fill → WRITE.
- DONE: done=1 for exactly one cycle; busy=1; next state IDLE.
- busy = (state != IDLE).
- Latency, counting from the edge that samples start:
  - Copy of N ≥ 1 words: 2N cycles of memory traffic, then 1 DONE cycle.
  - Fill of N ≥ 1 words: N cycles of memory traffic, then 1 DONE cycle.
  - N = 0: DONE in the next cycle, with no memory access.
- mem_r_en and mem_w_en are never asserted in the same cycle.
- start while busy=1 is ignored and not queued. A new start is accepted in the IDLE cycle right after DONE.
- Pointers increment modulo 2^ADDR_W with no range check. Addressing outside the memory depth is the system's responsibility.
- Copy order is strictly ascending, one word at a time. Overlapping regions therefore behave as a sequential forward copy: if dst = src+1, src[0] propagates through the whole block.
- Inputs other than start are ignored after the start cycle.
- rst mid-operation:
  - Aborts at the next edge: IDLE, enables low, no done pulse.
  - Words already written stay written.

Test Plan:
1. Preload mem[0..3] = 11,22,33,44. Copy src=0, dst=10, count=4 → exactly 8 traffic cycles alternating R/W; mem[10..13] = 11,22,33,44; done pulses once in cycle 9; words_done=4.
2. Fill dst=20, count=3, fill_value=0xDEADBEEF → 3 consecutive mem_w_en cycles at addresses 20,21,22; mem_r_en never high; done in cycle 4.
3. count=0, copy mode → mem_r_en and mem_w_en stay 0; done=1 in the cycle after start; words_done=0.
4. Copy src=0 with mem[0]=7, dst=1, count=3 → mem[1..3] = 7,7,7, confirming ascending-order overlap semantics.
5. Start a 4-word copy; pulse start again in cycle 3 with different addresses → second request ignored; only the first operation's writes occur; exactly one done.
6. Assert rst during the WRITE of word 2 of a 4-word copy → the next cycle shows busy=0 and enables 0; no done pulse; word 1 remains written and word 2 is not written; a fresh start afterwards completes normally.

Source files
------------

// File: rtl/mem_block_mover_if.sv
// Control and memory-bus bundle of the block mover.
// master: requester + memory side; slave: the mover itself.
interface mem_block_mover_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 7
);
  logic              start;
  logic              mode;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [CNT_W-1:0]  word_count;
  logic [DATA_W-1:0] fill_value;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  words_done;
  logic              mem_r_en;
  logic              mem_w_en;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output start, mode, src_addr, dst_addr,
    output word_count, fill_value, mem_rdata,
    input  busy, done, words_done,
    input  mem_r_en, mem_w_en, mem_address, mem_wdata
  );

  modport slave (
    input  start, mode, src_addr, dst_addr,
    input  word_count, fill_value, mem_rdata,
    output busy, done, words_done,
    output mem_r_en, mem_w_en, mem_address, mem_wdata
  );
endinterface

// File: rtl/mem_block_mover.sv
// Block copy / memset engine, second master on the data memory.
// Ports: clk, rst (sync, active-high), bus (slave modport).
module mem_block_mover #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 7
) (
  input logic clk,
  input logic rst,
  mem_block_mover_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE, S_READ, S_WRITE, S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [CNT_W-1:0]  r_rem;
  logic [CNT_W-1:0]  r_words;
  logic              r_mode;
  logic [DATA_W-1:0] r_fill;
  logic [DATA_W-1:0] r_buf;

  logic              w_r_en;
  logic              w_w_en;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_rem   <= '0;
      r_words <= '0;
      r_mode  <= 1'b0;
      r_fill  <= '0;
      r_buf   <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_src   <= bus.src_addr;
            r_dst   <= bus.dst_addr;
            r_rem   <= bus.word_count;
            r_mode  <= bus.mode;
            r_fill  <= bus.fill_value;
            r_words <= '0;
          end
        end
        S_READ: begin
          r_buf <= bus.mem_rdata;
          r_src <= r_src + ADDR_W'(1);
        end
        S_WRITE: begin
          r_dst   <= r_dst + ADDR_W'(1);
          r_rem   <= r_rem - CNT_W'(1);
          r_words <= r_words + CNT_W'(1);
        end
        S_DONE: ;
      endcase
    end
  end

  always_comb begin
    w_next  = r_state;
    w_r_en  = 1'b0;
    w_w_en  = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.word_count == '0)
            w_next = S_DONE;
          else if (bus.mode)
            w_next = S_WRITE;
          else
            w_next = S_READ;
        end
      end
      S_READ: begin
        w_r_en = 1'b1;
        w_addr = r_src;
        w_next = S_WRITE;
      end
      S_WRITE: begin
        w_w_en  = 1'b1;
        w_addr  = r_dst;
        w_wdata = r_mode ? r_fill : r_buf;
        if (r_rem == CNT_W'(1))
          w_next = S_DONE;
        else if (r_mode)
          w_next = S_WRITE;
        else
          w_next = S_READ;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Reset wins even over the cycle it arrives in: the
  // in-flight access is suppressed, so an aborted write
  // never lands in memory.
  assign bus.mem_r_en    = w_r_en & ~rst;
  assign bus.mem_w_en    = w_w_en & ~rst;
  assign bus.mem_address = w_addr;
  assign bus.mem_wdata   = w_wdata;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = (r_state == S_DONE);
  assign bus.words_done  = r_words;

endmodule

// File: tb/tb_mem_block_mover.sv
// Bench for mem_block_mover: memory model, cycle-level
// reference of bus traffic, directed operations.
module tb_mem_block_mover;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_block_mover_if bus ();

  mem_block_mover dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        busy;
    logic        done;
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [6:0]  wc;
  } exp_t;

  exp_t exp_q[$];

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];

  logic        pl_en = 1'b0;
  logic [7:0]  pl_a  = '0;
  logic [31:0] pl_d  = '0;

  int n_err = 0;
  int n_chk = 0;
  bit chk_on = 1'b0;

  int cyc_cnt  = 0;
  int done_cnt = 0;
  int rd_cnt   = 0;
  int wr_cnt   = 0;
  int done_cyc = 0;

  int start_cyc;
  int base_done;
  int base_rd;
  int base_wr;

  always @(posedge clk) begin
    if (bus.mem_w_en)
      mem[bus.mem_address[7:0]] <= bus.mem_wdata;
    else if (pl_en)
      mem[pl_a] <= pl_d;
  end

  assign bus.mem_rdata = mem[bus.mem_address[7:0]];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      exp_t e;
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc_cnt;
      end
      if (bus.mem_r_en === 1'b1) rd_cnt++;
      if (bus.mem_w_en === 1'b1) wr_cnt++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("busy", 64'(bus.busy), 64'(e.busy));
        chk("done", 64'(bus.done), 64'(e.done));
        chk("r_en", 64'(bus.mem_r_en), 64'(e.r));
        chk("w_en", 64'(bus.mem_w_en), 64'(e.w));
        chk("addr", 64'(bus.mem_address), 64'(e.a));
        chk("wdata", 64'(bus.mem_wdata), 64'(e.wd));
        chk("words_done", 64'(bus.words_done),
            64'(e.wc));
      end else begin
        chk("idle_busy", 64'(bus.busy), 64'(0));
        chk("idle_r_en", 64'(bus.mem_r_en), 64'(0));
        chk("idle_w_en", 64'(bus.mem_w_en), 64'(0));
      end
    end
  end

  function automatic void push(logic b, logic d,
                               logic r, logic w,
                               int a, logic [31:0] wd,
                               int wc);
    exp_t e;
    e.busy = b;
    e.done = d;
    e.r    = r;
    e.w    = w;
    e.a    = 32'(a);
    e.wd   = wd;
    e.wc   = 7'(wc);
    exp_q.push_back(e);
  endfunction

  // Reference: the operation as a plain word-by-word loop.
  // cut = cycle number (1-based) in which rst is high.
  function automatic void model_op(bit md, int src,
                                   int dst, int n,
                                   logic [31:0] fill,
                                   int cut);
    int c = 0;
    logic [31:0] v;
    if (n == 0) begin
      push(1, 1, 0, 0, 0, 0, 0);
      push(0, 0, 0, 0, 0, 0, 0);
      return;
    end
    for (int i = 0; i < n; i++) begin
      if (!md) begin
        c++;
        if (c == cut) begin
          push(1, 0, 0, 0, src + i, 0, i);
          push(0, 0, 0, 0, 0, 0, 0);
          return;
        end
        push(1, 0, 1, 0, src + i, 0, i);
        v = ref_mem[8'(src + i)];
      end else begin
        v = fill;
      end
      c++;
      if (c == cut) begin
        push(1, 0, 0, 0, dst + i, v, i);
        push(0, 0, 0, 0, 0, 0, 0);
        return;
      end
      push(1, 0, 0, 1, dst + i, v, i);
      ref_mem[8'(dst + i)] = v;
    end
    push(1, 1, 0, 0, 0, 0, n);
    push(0, 0, 0, 0, 0, 0, n);
  endfunction

  task automatic preload(int a, logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1;
    pl_a  = 8'(a);
    pl_d  = d;
    ref_mem[8'(a)] = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic do_op(bit md, int src, int dst, int n,
                       logic [31:0] fill, int cut);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.mode       = md;
    bus.src_addr   = 32'(src);
    bus.dst_addr   = 32'(dst);
    bus.word_count = 7'(n);
    bus.fill_value = fill;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    start_cyc  = cyc_cnt;
    base_done  = done_cnt;
    base_rd    = rd_cnt;
    base_wr    = wr_cnt;
    model_op(md, src, dst, n, fill, cut);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_q.size() > 0; i++)
      @(posedge clk);
    if (exp_q.size() > 0) begin
      chk("drain_timeout", 64'(exp_q.size()), 64'(0));
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  function automatic int done_k();
    return done_cyc - start_cyc + 1;
  endfunction

  initial begin
    bus.start      = 1'b0;
    bus.mode       = 1'b0;
    bus.src_addr   = '0;
    bus.dst_addr   = '0;
    bus.word_count = '0;
    bus.fill_value = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;

    @(posedge clk);
    #1;
    push(0, 0, 0, 0, 0, 0, 0);
    push(0, 0, 0, 0, 0, 0, 0);
    chk_on = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    wait_drain();

    // 1: plain 4-word copy
    preload(0, 11);
    preload(1, 22);
    preload(2, 33);
    preload(3, 44);
    for (int i = 10; i < 14; i++) preload(i, 0);
    do_op(0, 0, 10, 4, 0, -1);
    wait_drain();
    chk("t1_done_cycle", 64'(done_k()), 64'(9));
    chk("t1_reads", 64'(rd_cnt - base_rd), 64'(4));
    chk("t1_writes", 64'(wr_cnt - base_wr), 64'(4));
    chk("t1_dones", 64'(done_cnt - base_done), 64'(1));
    chk("t1_mem10", 64'(mem[10]), 64'(11));
    chk("t1_mem11", 64'(mem[11]), 64'(22));
    chk("t1_mem12", 64'(mem[12]), 64'(33));
    chk("t1_mem13", 64'(mem[13]), 64'(44));
    chk("t1_model13", 64'(ref_mem[13]), 64'(44));

    // 2: fill 3 words
    do_op(1, 0, 20, 3, 32'hDEADBEEF, -1);
    wait_drain();
    chk("t2_done_cycle", 64'(done_k()), 64'(4));
    chk("t2_reads", 64'(rd_cnt - base_rd), 64'(0));
    chk("t2_writes", 64'(wr_cnt - base_wr), 64'(3));
    chk("t2_mem20", 64'(mem[20]), 64'hDEADBEEF);
    chk("t2_mem22", 64'(mem[22]), 64'hDEADBEEF);

    // 3: zero-length copy
    do_op(0, 5, 30, 0, 0, -1);
    wait_drain();
    chk("t3_done_cycle", 64'(done_k()), 64'(1));
    chk("t3_access",
        64'((rd_cnt - base_rd) + (wr_cnt - base_wr)),
        64'(0));
    chk("t3_dones", 64'(done_cnt - base_done), 64'(1));

    // 4: overlapping forward copy
    preload(0, 7);
    do_op(0, 0, 1, 3, 0, -1);
    wait_drain();
    chk("t4_mem1", 64'(mem[1]), 64'(7));
    chk("t4_mem2", 64'(mem[2]), 64'(7));
    chk("t4_mem3", 64'(mem[3]), 64'(7));
    chk("t4_model3", 64'(ref_mem[3]), 64'(7));

    // 5: start while busy is ignored
    for (int i = 0; i < 4; i++) preload(40 + i, 32'h100 + i);
    preload(60, 32'h55);
    do_op(0, 40, 50, 4, 0, -1);
    repeat (2) @(posedge clk);
    #1;
    bus.start      = 1'b1;
    bus.mode       = 1'b1;
    bus.src_addr   = 32'd0;
    bus.dst_addr   = 32'd60;
    bus.word_count = 7'd2;
    bus.fill_value = 32'hBAD;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_drain();
    chk("t5_dones", 64'(done_cnt - base_done), 64'(1));
    chk("t5_writes", 64'(wr_cnt - base_wr), 64'(4));
    chk("t5_mem50", 64'(mem[50]), 64'h100);
    chk("t5_mem53", 64'(mem[53]), 64'h103);
    chk("t5_mem60", 64'(mem[60]), 64'h55);

    // 6: reset during the second write
    for (int i = 0; i < 4; i++) preload(70 + i, 32'hA0 + i);
    for (int i = 0; i < 4; i++) preload(80 + i, 0);
    do_op(0, 70, 80, 4, 0, 4);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    wait_drain();
    chk("t6_dones", 64'(done_cnt - base_done), 64'(0));
    chk("t6_mem80", 64'(mem[80]), 64'hA0);
    chk("t6_mem81", 64'(mem[81]), 64'h0);
    do_op(0, 70, 80, 4, 0, -1);
    wait_drain();
    chk("t6_redo_dones", 64'(done_cnt - base_done),
        64'(1));
    chk("t6_mem81b", 64'(mem[81]), 64'hA1);
    chk("t6_mem83", 64'(mem[83]), 64'hA3);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
